// File: rtl/viterbi_frame_ctrl_if.sv
// Frame controller bus: upstream symbol handshake, Viterbi core side-band, downstream bits and status.
// Latency: none, wires only.
// Backpressure: sym_ready_o qualifies sym_valid_i; downstream bits have no ready (core output is not stallable).
//
// Signals (named from the controller's point of view):
//   start_i, abort_i, cfg_len_i     frame control from the host
//   sym_i, sym_valid_i, sym_ready_o coded symbol stream from upstream
//   core_sym_o, core_valid_o,
//   core_clr_o                      symbol/advance/clear towards the Viterbi core
//   core_bit_i, core_bit_valid_i    decoded bits from the traceback unit
//   bit_o, bit_valid_o              decoded bits towards downstream
//   busy_o, done_o, err_o           status
interface viterbi_frame_ctrl_if #(
   parameter int LEN_W = 16
);
   logic             start_i;
   logic             abort_i;
   logic [LEN_W-1:0] cfg_len_i;
   logic [1:0]       sym_i;
   logic             sym_valid_i;
   logic             sym_ready_o;
   logic [1:0]       core_sym_o;
   logic             core_valid_o;
   logic             core_clr_o;
   logic             core_bit_i;
   logic             core_bit_valid_i;
   logic             bit_o;
   logic             bit_valid_o;
   logic             busy_o;
   logic             done_o;
   logic             err_o;

   // Controller side.
   modport slave (
      input  start_i, abort_i, cfg_len_i, sym_i, sym_valid_i, core_bit_i, core_bit_valid_i,
      output sym_ready_o, core_sym_o, core_valid_o, core_clr_o, bit_o, bit_valid_o,
             busy_o, done_o, err_o
   );

   // Host / upstream / core / downstream side.
   modport master (
      output start_i, abort_i, cfg_len_i, sym_i, sym_valid_i, core_bit_i, core_bit_valid_i,
      input  sym_ready_o, core_sym_o, core_valid_o, core_clr_o, bit_o, bit_valid_o,
             busy_o, done_o, err_o
   );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the Viterbi core: clear, pace LEN symbols, inject FLUSH_LEN zero tails, forward LEN bits.
// Latency: accepted symbol -> core_valid_o 1 cycle; core_bit_valid_i -> bit_valid_o 1 cycle.
// Backpressure: sym_ready_o high only in DATA (and not while aborting); missing symbols pause the core.
//
// Ports: clk, rst (async, active-high); bus = viterbi_frame_ctrl_if.slave (see interface for signal list).
module viterbi_frame_ctrl #(
   parameter int LEN_W     = 16,
   parameter int FLUSH_LEN = 15,
   parameter int DRAIN_TMO = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   viterbi_frame_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_DATA,
      S_FLUSH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] in_cnt_q, out_cnt_q, flush_cnt_q, drain_cnt_q;
   logic [1:0]       core_sym_q;
   logic             core_valid_q;
   logic             bit_q, bit_valid_q;
   logic             err_q, clr_q;

   // Per-cycle control decisions from the FSM.
   logic sym_rdy;
   logic issue_data, issue_flush;
   logic fwd_en, fwd_bit;
   logic latch_len, clr_cnt, drain_inc;
   logic err_d, clr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sym_rdy     = 1'b0;
      issue_data  = 1'b0;
      issue_flush = 1'b0;
      fwd_bit     = 1'b0;
      latch_len   = 1'b0;
      clr_cnt     = 1'b0;
      drain_inc   = 1'b0;
      err_d       = 1'b0;
      clr_d       = 1'b0;
      // Bits past LEN are swallowed so downstream sees exactly LEN bits.
      fwd_en      = bus.core_bit_valid_i && (out_cnt_q < len_q);

      case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               if (bus.cfg_len_i != '0) begin
                  latch_len = 1'b1;
                  state_d   = S_CLEAR;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            clr_cnt = 1'b1;
            state_d = S_DATA;
         end
         S_DATA: begin
            sym_rdy = 1'b1;
            fwd_bit = fwd_en;
            if (bus.sym_valid_i) begin
               issue_data = 1'b1;
               if (in_cnt_q == len_q - LEN_W'(1)) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            fwd_bit     = fwd_en;
            issue_flush = 1'b1;
            if (flush_cnt_q == LEN_W'(FLUSH_LEN - 1)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            fwd_bit   = fwd_en;
            drain_inc = 1'b1;
            if (out_cnt_q == len_q) begin
               state_d = S_DONE;
            end else if (drain_cnt_q == LEN_W'(DRAIN_TMO - 1)) begin
               // Core stopped delivering bits; give up on the frame but still report completion.
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort beats everything: no symbol is taken, nothing is issued or forwarded,
      // and the core is cleared so the next frame starts from clean metrics.
      if (bus.abort_i && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         sym_rdy     = 1'b0;
         issue_data  = 1'b0;
         issue_flush = 1'b0;
         fwd_bit     = 1'b0;
         drain_inc   = 1'b0;
         latch_len   = 1'b0;
         err_d       = 1'b1;
         clr_d       = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q        <= '0;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         flush_cnt_q  <= '0;
         drain_cnt_q  <= '0;
         core_sym_q   <= 2'b00;
         core_valid_q <= 1'b0;
         bit_q        <= 1'b0;
         bit_valid_q  <= 1'b0;
         err_q        <= 1'b0;
         clr_q        <= 1'b0;
      end else begin
         if (latch_len) begin
            len_q <= bus.cfg_len_i;
         end
         if (clr_cnt) begin
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            flush_cnt_q <= '0;
            drain_cnt_q <= '0;
         end else begin
            if (issue_data)  in_cnt_q    <= in_cnt_q + LEN_W'(1);
            if (issue_flush) flush_cnt_q <= flush_cnt_q + LEN_W'(1);
            if (drain_inc)   drain_cnt_q <= drain_cnt_q + LEN_W'(1);
            if (fwd_bit)     out_cnt_q   <= out_cnt_q + LEN_W'(1);
         end

         // Symbol register holds its value on idle cycles; the core only looks at it with core_valid_o.
         core_valid_q <= issue_data | issue_flush;
         if (issue_data) begin
            core_sym_q <= bus.sym_i;
         end else if (issue_flush) begin
            core_sym_q <= 2'b00;
         end

         bit_valid_q <= fwd_bit;
         if (fwd_bit) begin
            bit_q <= bus.core_bit_i;
         end

         err_q <= err_d;
         clr_q <= clr_d;
      end
   end

   assign bus.sym_ready_o  = sym_rdy;
   assign bus.core_sym_o   = core_sym_q;
   assign bus.core_valid_o = core_valid_q;
   // Clear comes from the CLEAR state itself or from the cycle after an abort.
   assign bus.core_clr_o   = (state_q == S_CLEAR) | clr_q;
   assign bus.bit_o        = bit_q;
   assign bus.bit_valid_o  = bit_valid_q;
   assign bus.busy_o       = (state_q != S_IDLE);
   assign bus.done_o       = (state_q == S_DONE);
   assign bus.err_o        = err_q;

endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
- Frame-level sequencer in front of the Viterbi core (branch metric, ACS and traceback unit).
- Accepts a per-frame length and an upstream 2-bit coded-symbol stream, and clears the core at frame start.
- Paces symbols into the core, then appends FLUSH_LEN zero tail symbols so the traceback pipeline empties.
- Forwards exactly the first LEN decoded bits downstream, then signals done; a drain watchdog prevents hangs.

Parameters:
- LEN_W, 16, width of the frame-length field and of the internal counters.
- FLUSH_LEN, 15, number of zero tail symbols injected after the last data symbol; matches the traceback depth TBL.
- DRAIN_TMO, 64, maximum cycles spent in DRAIN before it is aborted with an error.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  frame start pulse, honoured only in IDLE.
- abort_i  in  1  abandon the current frame.
- cfg_len_i  in  LEN_W  frame length in info bits, sampled on an accepted start_i.
- sym_i  in  2  coded symbol pair from upstream.
- sym_valid_i  in  1  upstream symbol valid.
- sym_ready_o  out  1  controller accepts a symbol this cycle.
- core_sym_o  out  2  symbol presented to the core.
- core_valid_o  out  1  core advance strobe (the core's valid input).
- core_clr_o  out  1  one-cycle clear of core path metrics and survivor paths.
- core_bit_i  in  1  decoded bit from the traceback unit.
- core_bit_valid_i  in  1  decoded bit valid.
- bit_o  out  1  decoded bit to downstream.
- bit_valid_o  out  1  decoded bit valid.
- busy_o  out  1  high whenever the state is not IDLE.
- done_o  out  1  one-cycle pulse at frame completion.
- err_o  out  1  one-cycle error pulse.

Behaviour:
- Reset: state=IDLE, all counters 0, every output 0.
- States: IDLE, CLEAR, DATA, FLUSH, DRAIN, DONE.
- IDLE:
  - start_i with cfg_len_i!=0: latch LEN, go to CLEAR.
  - start_i with cfg_len_i==0: pulse err_o next cycle, stay in IDLE.
- CLEAR: core_clr_o=1 for exactly this one cycle; in_cnt=0, out_cnt=0, flush_cnt=0; go to DATA.
- DATA:
  - sym_ready_o=1 combinationally.
  - On a handshake (sym_valid_i & sym_ready_o): next cycle core_valid_o=1 and core_sym_o=sym_i; in_cnt increments.
  - Cycles without a handshake: core_valid_o=0 and core_sym_o holds (the core pauses).
  - The handshake that makes in_cnt==LEN moves the state to FLUSH; sym_ready_o is 0 from that following cycle on.
- FLUSH:
  - core_valid_o=1 and core_sym_o=2'b00 on every cycle for FLUSH_LEN consecutive cycles, counted by flush_cnt.
  - Then go to DRAIN.
- DRAIN:
  - core_valid_o=0; a cycle counter runs.
  - Go to DONE when out_cnt==LEN.
  - If the counter reaches DRAIN_TMO first: pulse err_o, then go to DONE.
- Output forwarding, active in DATA, FLUSH and DRAIN:
  - When core_bit_valid_i=1 and out_cnt<LEN: registered, bit_o=core_bit_i and bit_valid_o=1 one cycle later; out_cnt increments.
  - Core bits beyond LEN, and core bits arriving in IDLE, CLEAR or DONE, are dropped and never raise bit_valid_o.
- DONE: done_o=1 for one cycle, then go to IDLE; busy_o drops the cycle after DONE.
- abort_i, from any state other than IDLE:
  - Next cycle: core_valid_o=0, sym_ready_o=0, core_clr_o pulse, err_o pulse; go to IDLE without done_o.
  - abort_i has priority over every other transition.
- start_i while busy is ignored; it does not re-latch LEN and raises no err_o.
- Counters are LEN_W wide and never wrap: in_cnt ≤ LEN, out_cnt ≤ LEN.
- If the final data handshake and a core bit arrive in the same cycle, both are processed.
- Assertion of rst at any point returns immediately (asynchronously) to the reset values; no partial frame resumes.
- Latency:
  - Accepted symbol to core_valid_o: 1 cycle.
  - core_bit_valid_i to bit_valid_o: 1 cycle.

Test Plan:
- Basic frame: LEN=20, sym_valid_i held high → 1 core_clr_o pulse, 20 data strobes, then 15 zero strobes; exactly 20 bit_valid_o pulses; done_o once; err_o never.
- Backpressure gaps: LEN=8, sym_valid_i toggling 1/0 → core_valid_o follows each handshake 1 cycle later with correct symbols; 8 data strobes plus 15 flush strobes; done_o once.
- Excess core bits: bench model returns 25 bits for LEN=10 → exactly 10 bits forwarded, bits 11–25 dropped, done_o once.
- Watchdog: core stops producing bits after 5 of LEN=10 → err_o pulses after 64 DRAIN cycles, then done_o, then busy_o=0.
- Zero length and busy start: start_i with cfg_len_i=0 → err_o pulse, busy_o stays 0; start_i mid-frame → ignored, frame completes with the original LEN.
- Abort and reset: abort_i during FLUSH → core_clr_o and err_o pulse, no done_o, IDLE next cycle; rst asserted during DATA → all outputs 0 immediately, IDLE.
